// File: rtl/type_param_rr_arbiter.sv
// type_param_rr_arbiter: round-robin arbiter for a typed payload channel,
// with optional packet locking and one registered output stage.
module type_param_rr_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter type PAYLOAD_T = logic [7:0],
  parameter bit  LOCK_EN   = 1'b1,
  parameter int  SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  PAYLOAD_T           req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_last,
  output logic               out_valid,
  input  logic               out_ready,
  output PAYLOAD_T           out_data,
  output logic               out_last,
  output logic [SRC_W-1:0]   out_src,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   lock_idx;
  logic [SRC_W-1:0]   cand;
  logic [SRC_W-1:0]   gidx;
  logic [SRC_W-1:0]   next_ptr;
  logic               found;
  logic               load_ok;
  logic               xfer;
  logic [NUM_REQ-1:0] grant_c;

  assign load_ok = !out_valid || out_ready;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        cand  = SRC_W'(idx);
      end
    end
  end

  assign gidx = (state == LOCKED) ? lock_idx : cand;

  always_comb begin
    grant_c = '0;
    if (rst_n && (state == LOCKED || found))
      grant_c[gidx] = 1'b1;
  end

  assign grant     = grant_c;
  assign req_ready = grant_c & {NUM_REQ{load_ok}};
  assign xfer      = |(req_valid & req_ready);
  assign busy      = (state == LOCKED) || out_valid;
  assign next_ptr  = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      rr_ptr    <= '0;
      lock_idx  <= '0;
      state     <= IDLE;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= req_data[gidx];
        out_last  <= req_last[gidx];
        out_src   <= gidx;
        if (req_last[gidx] || !LOCK_EN) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end else begin
          state    <= LOCKED;
          lock_idx <= gidx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_type_param_rr_arbiter.sv
// tb_type_param_rr_arbiter: random packet traffic against a cycle model,
// locked and unlocked variants, plus a struct-payload instance.
module tb_type_param_rr_arbiter;

  localparam int N = 4;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [3:0]  a;
    logic [11:0] b;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid, req_last;
  byte_t        req_data [N];
  logic         out_ready;

  logic [N-1:0] l_ready, l_grant;
  logic         l_ov, l_ol, l_busy;
  byte_t        l_od;
  logic [1:0]   l_os;

  logic [N-1:0] n_ready, n_grant;
  logic         n_ov, n_ol, n_busy;
  byte_t        n_od;
  logic [1:0]   n_os;

  logic [1:0] s_valid, s_last, s_ready, s_grant;
  pl_t        s_data [2];
  logic       s_oready, s_ov, s_ol, s_busy, s_os;
  pl_t        s_od;

  type_param_rr_arbiter #(.NUM_REQ(N), .LOCK_EN(1'b1)) u_lock (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(l_ready),
    .req_data(req_data), .req_last(req_last),
    .out_valid(l_ov), .out_ready(out_ready),
    .out_data(l_od), .out_last(l_ol), .out_src(l_os),
    .grant(l_grant), .busy(l_busy)
  );

  type_param_rr_arbiter #(.NUM_REQ(N), .LOCK_EN(1'b0)) u_nolock (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(n_ready),
    .req_data(req_data), .req_last(req_last),
    .out_valid(n_ov), .out_ready(out_ready),
    .out_data(n_od), .out_last(n_ol), .out_src(n_os),
    .grant(n_grant), .busy(n_busy)
  );

  type_param_rr_arbiter #(.NUM_REQ(2), .PAYLOAD_T(pl_t)) u_struct (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_data(s_data), .req_last(s_last),
    .out_valid(s_ov), .out_ready(s_oready),
    .out_data(s_od), .out_last(s_ol), .out_src(s_os),
    .grant(s_grant), .busy(s_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // model of the arbiter selected by sel (0 = locking, 1 = non-locking)
  bit    sel;
  int    m_ptr, m_lidx, m_os;
  bit    m_lock, m_ov, m_ol;
  byte_t m_od;
  int    rem [N];
  int    stall_cnt;

  task automatic set_beat(input int i);
    req_data[i]  = 8'($urandom);
    req_valid[i] = rem[i] > 0;
    req_last[i]  = rem[i] == 1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lidx = 0; m_lock = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    stall_cnt = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      set_beat(i);
    end
  endtask

  task automatic step();
    int g;
    logic ld, xf;
    logic [N-1:0] eg;
    @(negedge clk);
    g = -1;
    if (m_lock) g = m_lidx;
    else
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    eg = (g >= 0) ? (4'(1) << g) : '0;
    ld = !m_ov || out_ready;
    chk("grant", 32'(sel ? n_grant : l_grant), 32'(eg));
    chk("req_ready", 32'(sel ? n_ready : l_ready), 32'(ld ? eg : '0));
    chk("out_valid", 32'(sel ? n_ov : l_ov), 32'(m_ov));
    chk("busy", 32'(sel ? n_busy : l_busy), 32'(m_ov || m_lock));
    if (m_ov) begin
      chk("out_data", 32'(sel ? n_od : l_od), 32'(m_od));
      chk("out_last", 32'(sel ? n_ol : l_ol), 32'(m_ol));
      chk("out_src", 32'(sel ? n_os : l_os), 32'(m_os));
    end
    xf = (g >= 0) && ld && req_valid[g];
    @(posedge clk);
    #1;
    if (xf) begin
      m_ov = 1; m_od = req_data[g]; m_ol = req_last[g]; m_os = g;
      if (req_last[g] || sel) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_lock = 1;
        m_lidx = g;
      end
      rem[g]--;
      set_beat(g);
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int i = 0; i < N; i++)
      if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
        rem[i] = $urandom_range(1, 4);
        set_beat(i);
      end
    out_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (stall_cnt > 0) stall_cnt--;
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) begin
      rem[i] = $urandom_range(1, 4);
      set_beat(i);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(sel ? n_ov : l_ov), 32'd0);
    chk("rst_busy", 32'(sel ? n_busy : l_busy), 32'd0);
    chk("rst_grant", 32'(sel ? n_grant : l_grant), 32'd0);
    model_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 1;
      set_beat(i);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(sel ? n_grant : l_grant), 32'd1);
  endtask

  initial begin
    bit seen;
    sel = 0;
    out_ready = 1'b0;
    s_valid = '0; s_last = '0; s_oready = 1'b0;
    s_data[0] = '0; s_data[1] = '0;
    model_reset();
    fill_all();
    repeat (2) @(negedge clk);
    chk("rst_l_grant", 32'(l_grant), 32'd0);
    chk("rst_l_ready", 32'(l_ready), 32'd0);
    chk("rst_l_valid", 32'(l_ov), 32'd0);
    chk("rst_l_busy", 32'(l_busy), 32'd0);
    chk("rst_l_data", 32'(l_od), 32'd0);
    chk("rst_l_src", 32'(l_os), 32'd0);
    chk("rst_n_grant", 32'(n_grant), 32'd0);
    chk("rst_s_data", {16'h0, s_od}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 0; c < 300; c++) begin
      if (c == 100) begin
        fill_all();
        stall_cnt = 6;
        out_ready = 1'b0;
      end
      step();
    end

    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      seen = m_lock;
    end
    chk("lock_seen", 32'(seen), 32'd1);
    pulse_reset();
    for (int c = 0; c < 300; c++) step();

    sel = 1;
    pulse_reset();
    for (int c = 0; c < 300; c++) begin
      if (c == 50) begin
        fill_all();
        stall_cnt = 6;
        out_ready = 1'b0;
      end
      step();
    end

    s_oready = 1'b1;
    s_valid = 2'b01; s_last = 2'b01;
    s_data[0] = '{a: 4'h5, b: 12'hABC};
    @(posedge clk);
    #1;
    s_valid = 2'b10; s_last = 2'b10;
    s_data[1] = '{a: 4'hA, b: 12'h123};
    chk("st_valid0", 32'(s_ov), 32'd1);
    chk("st_data0", {16'h0, s_od}, 32'h5ABC);
    chk("st_src0", 32'(s_os), 32'd0);
    chk("st_last0", 32'(s_ol), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 2'b00;
    chk("st_data1", {16'h0, s_od}, 32'hA123);
    chk("st_src1", 32'(s_os), 32'd1);
    @(posedge clk);
    #1;
    chk("st_drain", 32'(s_ov), 32'd0);
    chk("st_hold", {16'h0, s_od}, 32'hA123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
